rf_wb_scheduler: RTL
====================

// Module: rf_wb_scheduler
// PURPOSE
// - Sequences the single write port of the 32-entry integer register file and tracks pending writes.
// - Up to NREQ writeback sources (ALU, LSU, MDU) compete for the one write port. A round-robin grant is registered into rd/din/we toward the register file.
// - A 32-bit busy scoreboard marks destinations that are issued but not yet written. It drives the decode-stage hazard stall (RAW and WAW).
// PARAMETERS
// - XLEN        32  data width of write port
// - NREQ         3  number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = MDU)
// - REG_ADDR_W   5  register index width
// PORTS
// - i_clk            in   1             clock, rising edge; the only clock
// - i_rst            in   1             reset, synchronous, active-high
// - i_issue_valid    in   1             decode wants to issue an instruction this cycle
// - i_issue_rd       in   REG_ADDR_W    destination of issuing instruction (0 = no write)
// - i_issue_rs1      in   REG_ADDR_W    source 1 index
// - i_issue_rs2      in   REG_ADDR_W    source 2 index
// - o_issue_stall    out  1             hazard: decode must hold; comb
// - i_wb_valid       in   NREQ          per-requester writeback request
// - i_wb_rd          in   NREQ*REG_ADDR_W  packed destination, requester k at [k*5+:5]
// - i_wb_data        in   NREQ*XLEN     packed write data, requester k at [k*XLEN+:XLEN]
// - o_wb_ready       out  NREQ          one-hot grant; handshake completes when valid&ready; comb
// - o_rf_rd          out  REG_ADDR_W    register file write index (registered)
// - o_rf_rd_din      out  XLEN          register file write data (registered)
// - o_rf_reg_write   out  1             register file write enable (registered)
// - o_busy           out  32            scoreboard, bit n = xn has a pending write (registered)
// BEHAVIOUR
// - Reset (i_rst high at a rising edge):
//   - o_rf_reg_write=0, o_rf_rd=0, o_rf_rd_din=0, o_busy=0, round-robin pointer=0.
//   - Reset mid-transfer drops the in-flight write and clears the whole scoreboard.
// - Arbitration:
//   - Round-robin starting at the pointer; at most one o_wb_ready bit high, only on a valid requester.
//   - After a grant to k, the pointer becomes (k+1) mod NREQ. The pointer is unchanged when there is no grant.
//   - Requesters hold valid, rd and data stable until ready. Dropping valid before ready is illegal; flag it with an assertion.
// - Write port: 1-cycle latency.
//   - Cycle after a grant to k: o_rf_reg_write=1, o_rf_rd=rd_k, o_rf_rd_din=data_k.
//   - No grant: o_rf_reg_write=0; rd and din hold their last values.
//   - Back-to-back grants give a write every cycle; throughput is 1 write per cycle.
// - Clear mask: clr = o_rf_reg_write ? onehot(o_rf_rd) : 0.
//   - The register file forwards write data combinationally in the write cycle, so the register being written counts as not busy in that cycle.
//   - eff_busy = o_busy & ~clr.
// - Stall: o_issue_stall = i_issue_valid & (eff_busy[rs1] | eff_busy[rs2] | eff_busy[rd]); index-0 terms are forced 0.
// - Set: set = (i_issue_valid & ~o_issue_stall & i_issue_rd!=0) ? onehot(i_issue_rd) : 0.
// - Scoreboard update:
//   - next o_busy = (o_busy & ~clr) | set.
//   - Same-register set and clear in the same cycle: set wins (the newer instruction owns the register).
//   - Bit 0 is always 0.
// - Writeback to x0: granted and forwarded with o_rf_reg_write=1 and o_rf_rd=0; the register file discards it; no scoreboard effect.
// - Writeback to a non-busy register: forwarded normally; clearing an already-clear bit is a no-op; flag it with an assertion.
// - All NREQ valid at once: served in rotating order, one per cycle. No requester waits more than NREQ-1 grants.
// STRUCTURE
// - rf_ctrl_pkg:
//   - REG_ADDR_W and NUM_REGS=32.
//   - wb_src_e enum {WB_ALU=0, WB_LSU=1, WB_MDU=2}.
//   - Function onehot32(idx).
// - Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs one-hot gnt[N] and next_ptr; purely combinational.
// - Top level holds the pointer flop, write-port flops and the 32-bit scoreboard flop.
// TESTING
// 1. Reset: assert i_rst 2 cycles with all valids high -> o_busy=0, o_rf_reg_write=0, o_wb_ready=0 during reset, and the first grant after reset goes to requester 0.
// 2. Single write: LSU valid, rd=5, data=32'hDEADBEEF -> o_wb_ready=3'b010 in the same cycle; next cycle o_rf_reg_write=1, o_rf_rd=5, o_rf_rd_din=32'hDEADBEEF.
// 3. Round-robin: all 3 valid, held -> grants 001,010,100,001 over 4 cycles; o_rf_reg_write high on each following cycle.
// 4. RAW stall: issue rd=7 (busy[7]=1), then issue rs1=7 -> stall=1 until the cycle o_rf_rd=7 with we=1, when stall=0 and busy[7]=0 the next cycle.
// 5. Set-wins: writeback to x9 in its write cycle while issue rd=9 -> no stall and busy[9] stays 1; issue rd=0 -> busy unchanged, never stalls.
// 6. Mid-operation reset: busy=32'h0000_0F00 and a grant pending -> reset next edge gives busy=0 and we=0; the dropped write is not emitted.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared register-file control definitions: register indexing, writeback source ids, decode helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package rf_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_MDU = 2'd2
    } wb_src_e;

    function automatic logic [NUM_REGS-1:0] onehot32(input logic [REG_ADDR_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Latency: purely combinational.
// Backpressure: requesters not granted simply wait; next_ptr equals ptr when nothing is granted.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] next_ptr
);

    always_comb begin
        int  idx;
        logic found;
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                next_ptr = PTR_W'((idx + 1) % N);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-port scheduler plus pending-write scoreboard for the 32-entry integer register file.
// Latency: grant is combinational; register-file write is issued one cycle after the grant.
// Backpressure: one writeback accepted per cycle via o_wb_ready; decode held by o_issue_stall.
module rf_wb_scheduler
    import rf_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREQ = int'(WB_MDU) + 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_issue_valid,
    input  logic [REG_ADDR_W-1:0]        i_issue_rd,
    input  logic [REG_ADDR_W-1:0]        i_issue_rs1,
    input  logic [REG_ADDR_W-1:0]        i_issue_rs2,
    output logic                         o_issue_stall,
    input  logic [NREQ-1:0]              i_wb_valid,
    input  logic [NREQ*REG_ADDR_W-1:0]   i_wb_rd,
    input  logic [NREQ*XLEN-1:0]         i_wb_data,
    output logic [NREQ-1:0]              o_wb_ready,
    output logic [REG_ADDR_W-1:0]        o_rf_rd,
    output logic [XLEN-1:0]              o_rf_rd_din,
    output logic                         o_rf_reg_write,
    output logic [NUM_REGS-1:0]          o_busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]      ptr_q, ptr_d, arb_next_ptr;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]       rf_din_q, rf_din_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d, clr, set, eff_busy;
    logic [NREQ-1:0]       req, gnt;

    // No handshake may complete while reset is held, so the in-flight slot stays empty.
    assign req = i_wb_valid & {NREQ{~i_rst}};

    rr_arbiter #(.N(NREQ), .PTR_W(PTR_W)) u_arb (
        .req      (req),
        .ptr      (ptr_q),
        .gnt      (gnt),
        .next_ptr (arb_next_ptr)
    );

    assign o_wb_ready = gnt;

    always_comb begin
        rf_we_d  = |gnt;
        rf_rd_d  = rf_rd_q;
        rf_din_d = rf_din_q;
        ptr_d    = arb_next_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                rf_rd_d  = i_wb_rd[k*REG_ADDR_W +: REG_ADDR_W];
                rf_din_d = i_wb_data[k*XLEN +: XLEN];
            end
        end
    end

    // The register being written this cycle is forwarded by the register file, so it is not a hazard.
    always_comb begin
        clr           = rf_we_q ? onehot32(rf_rd_q) : '0;
        eff_busy      = busy_q & ~clr;
        eff_busy[0]   = 1'b0;
        o_issue_stall = i_issue_valid & (eff_busy[i_issue_rs1] | eff_busy[i_issue_rs2] |
                                         eff_busy[i_issue_rd]);
        set           = (i_issue_valid && !o_issue_stall && i_issue_rd != '0) ?
                        onehot32(i_issue_rd) : '0;
        busy_d        = eff_busy | set;
        busy_d[0]     = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q    <= '0;
            rf_we_q  <= 1'b0;
            rf_rd_q  <= '0;
            rf_din_q <= '0;
            busy_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rf_we_q  <= rf_we_d;
            rf_rd_q  <= rf_rd_d;
            rf_din_q <= rf_din_d;
            busy_q   <= busy_d;
        end
    end

    assign o_rf_reg_write = rf_we_q;
    assign o_rf_rd        = rf_rd_q;
    assign o_rf_rd_din    = rf_din_q;
    assign o_busy         = busy_q;

    generate
        for (genvar k = 0; k < NREQ; k++) begin : g_req_hold
            a_req_hold: assert property (@(posedge i_clk) disable iff (i_rst)
                i_wb_valid[k] && !o_wb_ready[k] |=> i_wb_valid[k] &&
                $stable(i_wb_rd[k*REG_ADDR_W +: REG_ADDR_W]) && $stable(i_wb_data[k*XLEN +: XLEN]));
        end
    endgenerate

    a_wb_to_busy: assert property (@(posedge i_clk) disable iff (i_rst)
        rf_we_q && rf_rd_q != '0 |-> busy_q[rf_rd_q]);

endmodule
